// File: rtl/wb_trace_uart_pkg.sv
// Shared constants, FSM encoding and frame-byte helper for the writeback trace UART.
package wb_trace_uart_pkg;

   localparam logic [2:0] TRACE_SYNC        = 3'b101;
   localparam int         TRACE_FRAME_BYTES = 5;
   localparam int         TRACE_ENTRY_W     = 37;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   // Selects byte idx of the on-wire frame from a {brAddr, brDataIn} entry.
   // Byte 0 carries the sync pattern and register number, bytes 1..4 the data MSB first.
   function automatic logic [7:0] trace_frame_byte(input logic [TRACE_ENTRY_W-1:0] entry,
                                                   input logic [2:0]               idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = {TRACE_SYNC, entry[36:32]};
         3'd1:    b = entry[31:24];
         3'd2:    b = entry[23:16];
         3'd3:    b = entry[15:8];
         3'd4:    b = entry[7:0];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding queued writeback events. Full/empty come from the
// occupancy counter; pointers simply wrap because DEPTH is a power of two.
module trace_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 37
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic                   i_pop,
   input  logic [WIDTH-1:0]       i_din,
   output logic [WIDTH-1:0]       o_dout,
   output logic [$clog2(DEPTH):0] o_level,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_level;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == LW'(0));
   assign o_level = r_level;
   assign o_dout  = r_mem[r_rd_ptr];

   // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken then.
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);

   // Entry storage; contents need no reset because the level counter gates every read.
   always_ff @(posedge i_clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Read/write pointers and occupancy counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= AW'(0);
         r_rd_ptr <= AW'(0);
         r_level  <= LW'(0);
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr_en, w_rd_en})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/wb_trace_uart.sv
// Writeback trace: queues register-file writes and serializes each as a 5-byte
// UART 8N1 frame. Never back-pressures the core; overflowing events are counted.
module wb_trace_uart
   import wb_trace_uart_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 434,
   parameter int DROP_CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wbValid,
   input  logic [4:0]                  brAddr,
   input  logic [31:0]                 brDataIn,
   input  logic                        traceEn,
   output logic                        tx,
   output logic                        busy,
   output logic                        overflow,
   output logic [DROP_CNT_W-1:0]       dropCount,
   output logic [$clog2(FIFO_DEPTH):0] level
);

   localparam int            TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BYTE  = 3'(TRACE_FRAME_BYTES - 1);

   tx_state_e                r_state;
   tx_state_e                w_state_nxt;
   logic [TW-1:0]            r_timer;
   logic [TW-1:0]            w_timer_nxt;
   logic [2:0]               r_bit_idx;
   logic [2:0]               w_bit_nxt;
   logic [2:0]               r_byte_idx;
   logic [2:0]               w_byte_nxt;
   logic                     r_tx;
   logic                     w_tx_nxt;
   logic [TRACE_ENTRY_W-1:0] r_frame;
   logic                     r_overflow;
   logic [DROP_CNT_W-1:0]    r_drop_cnt;

   logic                     w_qual;
   logic                     w_pop;
   logic                     w_drop;
   logic                     w_full;
   logic                     w_empty;
   logic [TRACE_ENTRY_W-1:0] w_fifo_dout;
   logic [7:0]               w_cur_byte;
   logic [2:0]               w_bit_inc;

   // Writes to $zero are not architecturally visible and are never traced.
   assign w_qual = wbValid && traceEn && (brAddr != 5'd0);
   // Dropped only when full with no pop to make room in the same cycle.
   assign w_drop = w_qual && w_full && !w_pop;

   trace_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (TRACE_ENTRY_W)
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_push  (w_qual),
      .i_pop   (w_pop),
      .i_din   ({brAddr, brDataIn}),
      .o_dout  (w_fifo_dout),
      .o_level (level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_cur_byte = trace_frame_byte(r_frame, r_byte_idx);
   assign w_bit_inc  = r_bit_idx + 3'd1;

   assign tx        = r_tx;
   assign busy      = (r_state != ST_IDLE) || !w_empty;
   assign overflow  = r_overflow;
   assign dropCount = r_drop_cnt;

   // Next-state logic; w_tx_nxt is the line level for the cycle being entered.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_bit_nxt   = r_bit_idx;
      w_byte_nxt  = r_byte_idx;
      w_tx_nxt    = 1'b1;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = ST_LOAD;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            w_pop       = 1'b1;
            w_byte_nxt  = 3'd0;
            w_bit_nxt   = 3'd0;
            w_timer_nxt = BIT_RELOAD;
            w_state_nxt = ST_START;
            w_tx_nxt    = 1'b0;
         end
         ST_START: begin
            w_tx_nxt = 1'b0;
            if (r_timer == TW'(0)) begin
               w_timer_nxt = BIT_RELOAD;
               w_bit_nxt   = 3'd0;
               w_state_nxt = ST_DATA;
               w_tx_nxt    = w_cur_byte[0];
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         ST_DATA: begin
            w_tx_nxt = w_cur_byte[r_bit_idx];
            if (r_timer == TW'(0)) begin
               w_timer_nxt = BIT_RELOAD;
               if (r_bit_idx == 3'd7) begin
                  w_state_nxt = ST_STOP;
                  w_tx_nxt    = 1'b1;
               end else begin
                  w_bit_nxt = w_bit_inc;
                  w_tx_nxt  = w_cur_byte[w_bit_inc];
               end
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         ST_STOP: begin
            w_tx_nxt = 1'b1;
            if (r_timer == TW'(0)) begin
               w_timer_nxt = BIT_RELOAD;
               if (r_byte_idx < LAST_BYTE) begin
                  w_byte_nxt  = r_byte_idx + 3'd1;
                  w_state_nxt = ST_START;
                  w_tx_nxt    = 1'b0;
               end else if (!w_empty) begin
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_timer_nxt = r_timer - TW'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   // FSM state, bit timer, indices and the tx flop; reset returns the line to idle-high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= TW'(0);
         r_bit_idx  <= 3'd0;
         r_byte_idx <= 3'd0;
         r_tx       <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_bit_idx  <= w_bit_nxt;
         r_byte_idx <= w_byte_nxt;
         r_tx       <= w_tx_nxt;
      end
   end

   // Frame register captures the FIFO head on the pop cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frame <= {TRACE_ENTRY_W{1'b0}};
      end else if (w_pop) begin
         r_frame <= w_fifo_dout;
      end else begin
         r_frame <= r_frame;
      end
   end

   // Sticky overflow flag and saturating drop counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= {DROP_CNT_W{1'b0}};
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
         end else begin
            r_drop_cnt <= r_drop_cnt;
         end
      end else begin
         r_overflow <= r_overflow;
         r_drop_cnt <= r_drop_cnt;
      end
   end

endmodule
